// File: rtl/adaptive_filter_pkg.sv
// adaptive_filter_pkg
//   Shared definitions for the adaptive FIR datapaths (output MAC and weight
//   update). Holds the default word format, accumulator width, output
//   saturation bounds and the output-MAC FSM state encoding.
package adaptive_filter_pkg;

  localparam int WIDTH = 16;  // sample / weight / output word width
  localparam int QP    = 12;  // fractional bits, 1.0 = 1 << QP
  localparam int TAPS  = 8;   // filter length
  localparam int GUARD = 4;   // accumulator guard bits (>= clog2(TAPS))
  localparam int AW    = 3;   // tap / weight address width (clog2(TAPS))

  // Full-precision product plus guard bits: a sum of TAPS products never wraps.
  localparam int ACC_W = 2 * WIDTH + GUARD;

  // Output saturation bounds for the default word width.
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAST = 2'd2,
    ST_OUT  = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_output_mac_round_sat.sv
// round_sat
//   Combinational conversion of a wide signed accumulator to a WIDTH-bit
//   Q(WIDTH-QP).QP result: add half an LSB (round half toward +inf), shift
//   right arithmetically by QP, then clamp to the signed WIDTH-bit range.
//   Ports:
//     acc_i  ACC_W  signed accumulator value
//     y_o    WIDTH  rounded, saturated result
import adaptive_filter_pkg::*;

module round_sat #(
  parameter int WIDTH = adaptive_filter_pkg::WIDTH,
  parameter int QP    = adaptive_filter_pkg::QP,
  parameter int ACC_W = adaptive_filter_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [WIDTH-1:0] y_o
);

  // One extra bit so adding the rounding constant cannot overflow.
  localparam int EXT_W = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] RND =
    {{(EXT_W-QP){1'b0}}, 1'b1, {(QP-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] Y_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Y_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] MAX_E =
    {{(EXT_W-WIDTH){Y_MAX[WIDTH-1]}}, Y_MAX};
  localparam logic signed [EXT_W-1:0] MIN_E =
    {{(EXT_W-WIDTH){Y_MIN[WIDTH-1]}}, Y_MIN};

  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    rounded = $signed({acc_i[ACC_W-1], acc_i}) + RND;
    shifted = rounded >>> QP;
    if (shifted > MAX_E) begin
      y_o = Y_MAX;
    end else if (shifted < MIN_E) begin
      y_o = Y_MIN;
    end else begin
      y_o = shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_output_mac.sv
// fir_output_mac
//   Time-multiplexed FIR output stage: y(n) = sum_k w_k * x(n-k), using one
//   multiplier and one accumulator. Weights are read one tap per cycle from an
//   external bank with 1-cycle read latency. The module owns the tap delay
//   line and exposes any tap combinationally for the weight-update datapath.
//   Ports:
//     clk, reset    clock, synchronous active-high reset
//     x_in/x_valid  new sample and its one-cycle strobe
//     w_addr/w_rd_en/w_data  weight bank read port (data valid next cycle)
//     tap_sel/tap_data       delay-line tap read for the update path
//     y_out/y_valid          result (held) and its one-cycle update pulse
//     busy          high while a result is being computed (READ, LAST)
//     overrun       one-cycle pulse, one cycle after a dropped sample
//     dbg_state_o   current FSM state
//
//   Handshake: x_valid is a strobe with no backpressure. A strobe seen in IDLE
//   is accepted; a strobe in any other state is dropped, leaves the delay line
//   untouched, and is reported on overrun the following cycle.
import adaptive_filter_pkg::*;

module fir_output_mac #(
  parameter int WIDTH = adaptive_filter_pkg::WIDTH,
  parameter int QP    = adaptive_filter_pkg::QP,
  parameter int TAPS  = adaptive_filter_pkg::TAPS,
  parameter int GUARD = adaptive_filter_pkg::GUARD,
  parameter int AW    = adaptive_filter_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             x_valid,
  output logic [AW-1:0]    w_addr,
  output logic             w_rd_en,
  input  logic [WIDTH-1:0] w_data,
  input  logic [AW-1:0]    tap_sel,
  output logic [WIDTH-1:0] tap_data,
  output logic [WIDTH-1:0] y_out,
  output logic             y_valid,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       dbg_state_o
);

  localparam int           ACC_L  = 2 * WIDTH + GUARD;
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

  fir_state_e state_q, state_d;
  logic [AW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  taps_q [TAPS];
  logic [WIDTH-1:0]  x_pipe_q;     // tap value aligned with w_data
  logic              pipe_vld_q;   // x_pipe_q/w_data hold a product to add
  logic [ACC_L-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  y_out_q;
  logic              y_valid_q;
  logic              overrun_q;

  logic              accept;
  logic signed [2*WIDTH-1:0] prod;
  logic [ACC_L-1:0]  acc_sum;
  logic [WIDTH-1:0]  y_sat;

  assign accept  = (state_q == ST_IDLE) && x_valid;
  assign prod    = $signed(w_data) * $signed(x_pipe_q);
  assign acc_sum = acc_q + {{GUARD{prod[2*WIDTH-1]}}, prod};

  // The final product is folded in during LAST, so the rounded result of
  // acc_sum is registered on the LAST->OUT edge and is visible in OUT.
  round_sat #(.WIDTH(WIDTH), .QP(QP), .ACC_W(ACC_L)) u_round_sat (
    .acc_i (acc_sum),
    .y_o   (y_sat)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
      x_pipe_q   <= '0;
      pipe_vld_q <= 1'b0;
      acc_q      <= '0;
      y_out_q    <= '0;
      y_valid_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (accept) begin
        taps_q[0] <= x_in;
        for (int i = 1; i < TAPS; i++) taps_q[i] <= taps_q[i-1];
      end
      acc_q      <= acc_d;
      x_pipe_q   <= (state_q == ST_READ) ? taps_q[k_q] : '0;
      pipe_vld_q <= (state_q == ST_READ);
      y_valid_q  <= (state_q == ST_LAST);
      if (state_q == ST_LAST) y_out_q <= y_sat;
      overrun_q  <= x_valid && (state_q != ST_IDLE);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (pipe_vld_q) begin
      acc_d = acc_sum;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (x_valid) begin
          state_d = ST_READ;
          k_d     = '0;
        end
      end
      ST_READ: begin
        if (k_q == K_LAST) begin
          state_d = ST_LAST;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_LAST: state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_rd_en     = 1'b0;
    w_addr      = '0;
    busy        = 1'b0;
    case (state_q)
      ST_READ: begin
        w_rd_en = 1'b1;
        w_addr  = k_q;
        busy    = 1'b1;
      end
      ST_LAST: busy = 1'b1;
      default: ;
    endcase
    tap_data    = taps_q[tap_sel];
    y_out       = y_out_q;
    y_valid     = y_valid_q;
    overrun     = overrun_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_fir_output_mac.sv
// tb_fir_output_mac
//   Directed bench for fir_output_mac: impulse response, rounding boundary,
//   saturation, overrun, reset mid-computation and back-to-back streaming.
module tb_fir_output_mac;
  import adaptive_filter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] x_in;
  logic        x_valid;
  logic [2:0]  w_addr;
  logic        w_rd_en;
  logic [15:0] w_data = '0;
  logic [2:0]  tap_sel;
  logic [15:0] tap_data;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;
  logic [1:0]  dbg_state;

  fir_output_mac dut (
    .clk         (clk),
    .reset       (reset),
    .x_in        (x_in),
    .x_valid     (x_valid),
    .w_addr      (w_addr),
    .w_rd_en     (w_rd_en),
    .w_data      (w_data),
    .tap_sel     (tap_sel),
    .tap_data    (tap_data),
    .y_out       (y_out),
    .y_valid     (y_valid),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state_o (dbg_state)
  );

  // ---------------- weight bank (1-cycle read latency) ----------------
  logic signed [15:0] w_mem [8];
  always @(posedge clk) begin
    if (w_rd_en) w_data <= w_mem[w_addr];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic signed [15:0] m_taps [8];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (y_valid) begin
      if (exp_q.size() == 0) begin
        check("y_unexpected", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("y_out", $signed(y_out), $signed(mon_exp));
      end
    end
  end

  // Reference: exact sum, round half toward +inf, saturate.
  function automatic logic [15:0] ref_y();
    longint s;
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'(m_taps[k]) * longint'(w_mem[k]);
    s = (s + (longint'(1) << (QP - 1))) >>> QP;
    if (s > longint'(SAT_MAX)) return SAT_MAX;
    if (s < longint'(SAT_MIN)) return SAT_MIN;
    return 16'(s);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) m_taps[k] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    x_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_tap(input int sel, input int exp, input string tag);
    tap_sel = 3'(sel);
    #1;
    check(tag, $signed(tap_data), exp);
  endtask

  // Send one sample, optionally re-strobe x_valid dup_at cycles after the
  // accept, and wait (bounded) for its result.
  task automatic run_sample(input logic [15:0] x, input logic [15:0] exp_y,
                            input bit use_model, input int dup_at);
    int lat;
    lat = -1;
    @(negedge clk);
    x_in    = x;
    x_valid = 1'b1;
    for (int k = 7; k > 0; k--) m_taps[k] = m_taps[k-1];
    m_taps[0] = x;
    if (use_model) exp_q.push_back(ref_y());
    else           exp_q.push_back(exp_y);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("busy_read", busy, 1);
        check("rd_en_first", w_rd_en, 1);
        check("addr_first", w_addr, 0);
      end
      check("overrun", overrun, (dup_at != 0 && i == dup_at + 1) ? 1 : 0);
      if (y_valid) begin
        lat = i;
        check("busy_out", busy, 0);
        break;
      end
      x_valid = (dup_at != 0 && i == dup_at);
      x_in    = x_valid ? 16'd1234 : x;
    end
    check("latency", lat, 10);
  endtask

  logic [15:0] neg_exp [8] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFE0,
                               16'h8000, 16'h8000, 16'h8000, 16'h8000};
  logic signed [15:0] b2b_w [8] = '{16'sd1200, -16'sd3100, 16'sd4096, 16'sd2500,
                                    -16'sd800, 16'sd1500, -16'sd4096, 16'sd700};

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    reset   = 1'b1;
    x_valid = 1'b0;
    x_in    = '0;
    tap_sel = '0;
    for (int k = 0; k < 8; k++) w_mem[k] = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_y_out", y_out, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rd_en", w_rd_en, 0);
    check("rst_addr", w_addr, 0);
    check("rst_state", dbg_state, int'(ST_IDLE));
    for (int s = 0; s < 8; s++) check_tap(s, 0, "rst_tap");

    // Impulse response
    for (int k = 0; k < 8; k++) w_mem[k] = 16'(256 * (k + 1));
    for (int j = 0; j < 8; j++) begin
      run_sample((j == 0) ? 16'd4096 : 16'd0, 16'(256 * (j + 1)), 1'b0, 0);
      check_tap(j, 4096, "impulse_tap");
    end

    // Rounding boundary
    do_reset();
    for (int k = 0; k < 8; k++) w_mem[k] = '0;
    w_mem[0] = 16'sd2048;
    run_sample(16'd1, 16'd1, 1'b0, 0);
    w_mem[0] = 16'sd2047;
    run_sample(16'd1, 16'd0, 1'b0, 0);
    w_mem[0] = 16'sd2048;
    run_sample(16'hFFFF, 16'd0, 1'b0, 0);

    // Saturation: positive fill, then negative fill
    for (int k = 0; k < 8; k++) w_mem[k] = 16'sd32767;
    for (int j = 0; j < 8; j++) run_sample(16'h7FFF, 16'h7FFF, 1'b0, 0);
    for (int j = 0; j < 8; j++) run_sample(16'h8000, neg_exp[j], 1'b0, 0);

    // Overrun: re-strobe 3 cycles after accept
    do_reset();
    for (int k = 0; k < 8; k++) w_mem[k] = 16'(256 * (k + 1));
    run_sample(16'd4096, 16'd256, 1'b0, 3);
    check_tap(0, 4096, "overrun_tap0");
    check_tap(1, 0, "overrun_tap1");

    // Reset asserted while READ is at k=4
    @(negedge clk);
    x_in    = 16'd4096;
    x_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      x_valid = 1'b0;
      if (i == 5) begin
        check("addr_k4", w_addr, 4);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check("mid_y_out", y_out, 0);
    check("mid_y_valid", y_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_overrun", overrun, 0);
    check("mid_rd_en", w_rd_en, 0);
    check("mid_addr", w_addr, 0);
    check("mid_state", dbg_state, int'(ST_IDLE));
    for (int s = 0; s < 8; s++) check_tap(s, 0, "mid_tap");
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (y_valid) seen++;
    end
    check("no_y_after_reset", seen, 0);
    run_sample(16'd4096, 16'd256, 1'b0, 0);

    // Back-to-back at TAPS+3 spacing against the reference model
    do_reset();
    for (int k = 0; k < 8; k++) w_mem[k] = b2b_w[k];
    for (int j = 0; j < 16; j++) run_sample(16'($urandom_range(0, 65535)), 16'd0, 1'b1, 0);
    check_tap(3, int'(m_taps[3]), "b2b_tap3");
    check_tap(7, int'(m_taps[7]), "b2b_tap7");

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
